bcd_serial_adder: RTL and testbench

BCD_SERIAL_ADDER -- requirements
Module: bcd_serial_adder

---
 rtl/bcd_serial_adder.sv | 76 +++++++
 tb/tb_bcd_serial_adder.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/bcd_serial_adder.sv
// bcd_serial_adder: digit-serial packed-BCD adder, one digit per clock, lowest digit first.
module bcd_serial_adder #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  carry,
    output logic                  err
);
    localparam int W  = 4 * DIGITS;
    localparam int IW = $clog2(DIGITS + 1);
    localparam logic [1:0] IDLE = 2'd0, ADD = 2'd1, DONE = 2'd2;
    logic [1:0]    state;
    logic [W-1:0]  ra, rb, psum;
    logic          c, e;
    logic [IW-1:0] idx;
    logic [4:0]    raw, adj;
    logic [3:0]    dig;
    logic [W+3:0]  shifted;
    always_comb begin
        raw     = 5'(ra[3:0]) + 5'(rb[3:0]) + 5'(c);
        adj     = raw + 5'd6;
        dig     = raw > 5'd9 ? adj[3:0] : raw[3:0];
        shifted = {dig, psum};
    end
    assign busy = state != IDLE;
    assign done = state == DONE;
    // Operands shift down so digit i is always at [3:0]; the result shifts in from the top.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ra    <= '0;
            rb    <= '0;
            psum  <= '0;
            c     <= 1'b0;
            e     <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            carry <= 1'b0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    ra    <= a;
                    rb    <= b;
                    c     <= cin;
                    e     <= 1'b0;
                    idx   <= '0;
                    psum  <= '0;
                    state <= ADD;
                end
                ADD: if (idx == IW'(DIGITS)) begin
                    sum   <= psum;
                    carry <= c;
                    err   <= e;
                    state <= DONE;
                end else begin
                    ra   <= ra >> 4;
                    rb   <= rb >> 4;
                    c    <= raw > 5'd9;
                    e    <= e | (ra[3:0] > 4'd9) | (rb[3:0] > 4'd9);
                    psum <= shifted[W+3:4];
                    idx  <= idx + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_serial_adder.sv
// tb_bcd_serial_adder: random and directed stimulus checked every cycle against a behavioural model.
module tb_bcd_serial_adder;
    localparam int DIGITS = 4;
    localparam int W = 4 * DIGITS;
    logic clk, rst, start, cin, busy, done, carry, err;
    logic [W-1:0] a, b, sum;
    int vectors = 0, miscompares = 0, ndone = 0, lat;
    bit chk = 0;
    int cnt = 0;
    logic [W-1:0] es = '0;
    logic ec = 0, ee = 0;
    logic [W+1:0] pend, res, snap;

    bcd_serial_adder #(.DIGITS(DIGITS)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .carry(carry), .err(err)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Reference: per-digit decimal rule, returns {err, carry, sum}.
    function automatic logic [W+1:0] model_add(logic [W-1:0] x, logic [W-1:0] y, logic ci);
        int cc = ci;
        logic [W-1:0] s = '0;
        logic e = 0;
        for (int i = 0; i < DIGITS; i++) begin
            int ai = (x >> (4 * i)) & 15;
            int bi = (y >> (4 * i)) & 15;
            int r = ai + bi + cc;
            if (ai > 9 || bi > 9) e = 1;
            if (r > 9) begin s[4*i +: 4] = 4'((r + 6) % 16); cc = 1; end
            else begin s[4*i +: 4] = 4'(r); cc = 0; end
        end
        return {e, cc[0], s};
    endfunction

    function automatic int to_int(logic [W-1:0] x);
        int v = 0;
        for (int i = DIGITS - 1; i >= 0; i--) v = v * 10 + int'((x >> (4 * i)) & 15);
        return v;
    endfunction

    function automatic logic [W-1:0] rand_bcd(bit allow_bad);
        logic [W-1:0] v;
        for (int i = 0; i < DIGITS; i++)
            v[4*i +: 4] = (allow_bad && $urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        return v;
    endfunction

    // Transaction-level model: an accepted start makes the block busy for DIGITS+2 cycles,
    // the last of which is the done cycle when the result becomes visible.
    always @(posedge clk) begin
        if (rst) begin
            cnt = 0; es = '0; ec = 0; ee = 0;
        end else if (cnt == 0) begin
            if (start) begin cnt = DIGITS + 2; pend = model_add(a, b, cin); end
        end else begin
            cnt--;
            if (cnt == 1) {ee, ec, es} = pend;
        end
    end

    always @(negedge clk) if (chk) begin
        vectors++;
        if ({busy, done, carry, err, sum} !== {cnt > 0, cnt == 1, ec, ee, es}) begin
            miscompares++;
            $display("FAIL cycle t=%0t got busy=%b done=%b sum=%h carry=%b err=%b required busy=%b done=%b sum=%h carry=%b err=%b",
                     $time, busy, done, sum, carry, err, cnt > 0, cnt == 1, es, ec, ee);
        end
        if (done) ndone++;
    end

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got %h required %h", name, got, exp);
        end
    endtask

    task automatic go(logic [W-1:0] x, logic [W-1:0] y, logic ci);
        @(negedge clk);
        a = x; b = y; cin = ci; start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic wait_done(output int l);
        l = 0;
        while (!done && l < 20) begin @(negedge clk); l++; end
        check("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic op(string name, logic [W-1:0] x, logic [W-1:0] y, logic ci, logic [W+1:0] exp);
        go(x, y, ci);
        wait_done(lat);
        check({name, "_latency"}, lat, DIGITS + 1);
        check(name, {14'd0, err, carry, sum}, {14'd0, exp});
    endtask

    initial begin
        rst = 1; start = 1; a = 16'h1234; b = 16'h1111; cin = 0;
        @(negedge clk);
        chk = 1;
        check("reset_state", {13'd0, busy, done, err, carry, sum}, 32'd0);
        @(negedge clk);
        rst = 0; start = 0;
        check("model_1234_5678", 32'(model_add(16'h1234, 16'h5678, 0)), {14'd0, 2'b00, 16'h6912});
        check("model_9999_0001", 32'(model_add(16'h9999, 16'h0001, 0)), {14'd0, 2'b01, 16'h0000});
        check("model_cin_only", 32'(model_add(16'h0000, 16'h0000, 1)), {14'd0, 2'b00, 16'h0001});
        check("model_bad_digit", 32'(model_add(16'h000A, 16'h0000, 0)), {14'd0, 2'b10, 16'h0010});
        for (int i = 0; i < 20; i++) begin
            logic [W-1:0] x = rand_bcd(0), y = rand_bcd(0);
            logic ci = 1'($urandom_range(0, 1));
            int tot = to_int(x) + to_int(y) + int'(ci);
            res = model_add(x, y, ci);
            check("model_vs_decimal", res[W+1] * 1000000 + res[W] * 100000 + to_int(res[W-1:0]),
                  (tot >= 10000 ? 100000 : 0) + tot % 10000);
        end
        op("add_1234_5678", 16'h1234, 16'h5678, 0, {2'b00, 16'h6912});
        op("add_9999_0001", 16'h9999, 16'h0001, 0, {2'b01, 16'h0000});
        op("add_cin_only", 16'h0000, 16'h0000, 1, {2'b00, 16'h0001});
        op("add_bad_digit", 16'h000A, 16'h0000, 0, {2'b10, 16'h0010});
        // Starts while busy (in ADD and in DONE) must be dropped.
        repeat (2) @(negedge clk);
        lat = ndone;
        go(16'h1111, 16'h2222, 0);
        a = 16'h9999; b = 16'h9999;
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        @(negedge clk);
        @(negedge clk); start = 1;
        @(negedge clk);
        @(negedge clk); start = 0;
        repeat (12) @(negedge clk);
        check("busy_start_single_done", ndone - lat, 1);
        check("busy_start_sum", {14'd0, err, carry, sum}, {14'd0, 2'b00, 16'h3333});
        // Reset in the third ADD cycle aborts without a done pulse.
        lat = ndone;
        go(16'h5555, 16'h5555, 0);
        @(negedge clk);
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
        check("abort_outputs", {13'd0, busy, done, err, carry, sum}, 32'd0);
        repeat (10) @(negedge clk);
        check("abort_no_done", ndone - lat, 0);
        op("add_4321_1111_c", 16'h4321, 16'h1111, 1, {2'b00, 16'h5433});
        snap = {err, carry, sum};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a = ~a; b = b ^ 16'h5a5a;
            check("hold_outputs", {13'd0, done, err, carry, sum}, {14'd0, snap});
        end
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst = $urandom_range(0, 99) == 0;
            start = $urandom_range(0, 3) == 0;
            a = rand_bcd(1); b = rand_bcd(1);
            cin = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        rst = 0; start = 0;
        repeat (10) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
